// File: rtl/conv_encoder.sv
// Streaming rate-1/N_OUT convolutional encoder with valid/ready handshakes and frame delimiting.
// Optional zero-tail termination is enabled by defining CONV_ENC_TAIL_EN.
module conv_encoder #(
    parameter int                 K     = 5,
    parameter int                 N_OUT = 2,
    parameter logic [N_OUT*K-1:0] G_OCT = 10'h3B3,
    localparam int                M     = K - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_sym,
    output logic             out_last,
    output logic [M-1:0]     enc_state
);

    logic [M-1:0]     r_state;
    logic             r_out_valid;
    logic             r_out_last;
    logic [N_OUT-1:0] r_out_sym;
    logic             w_slot_free;
    logic             w_take;
    logic             w_bit;
    logic [K-1:0]     w_reg_vec;

    // Symbol bit N_OUT-1-i is the parity of the register masked by generator i.
    function automatic logic [N_OUT-1:0] encode_sym(input logic [K-1:0] reg_vec);
        logic [N_OUT-1:0] sym;
        sym = {N_OUT{1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            sym[N_OUT-1-i] = ^(reg_vec & G_OCT[i*K +: K]);
        end
        return sym;
    endfunction

    assign w_slot_free = !r_out_valid || out_ready;

`ifdef CONV_ENC_TAIL_EN
    localparam int CNT_W = $clog2(M + 1);
    typedef enum logic {ST_RUN = 1'b0, ST_TAIL = 1'b1} fsm_t;

    fsm_t             r_fsm;
    logic [CNT_W-1:0] r_tail_cnt;

    assign in_ready = (r_fsm == ST_RUN) && w_slot_free;
    assign w_bit    = (r_fsm == ST_RUN) ? in_bit : 1'b0;
`else
    assign in_ready = w_slot_free;
    assign w_bit    = in_bit;
`endif

    assign w_take    = in_valid && in_ready;
    assign w_reg_vec = {r_state, w_bit};

`ifdef CONV_ENC_TAIL_EN
    // Output register, shift state and tail sequencer; tail symbols feed zeros until the state drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= {M{1'b0}};
            r_out_valid <= 1'b0;
            r_out_sym   <= {N_OUT{1'b0}};
            r_out_last  <= 1'b0;
            r_fsm       <= ST_RUN;
            r_tail_cnt  <= {CNT_W{1'b0}};
        end else if (r_fsm == ST_TAIL) begin
            if (w_slot_free) begin
                r_out_sym   <= encode_sym(w_reg_vec);
                r_out_valid <= 1'b1;
                r_out_last  <= (r_tail_cnt == CNT_W'(1));
                r_state     <= w_reg_vec[M-1:0];
                r_tail_cnt  <= r_tail_cnt - CNT_W'(1);
                if (r_tail_cnt == CNT_W'(1)) begin
                    r_fsm <= ST_RUN;
                end else begin
                    r_fsm <= ST_TAIL;
                end
            end else begin
                r_out_valid <= r_out_valid;
            end
        end else if (w_take) begin
            r_out_sym   <= encode_sym(w_reg_vec);
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_state     <= w_reg_vec[M-1:0];
            if (in_last) begin
                r_fsm      <= ST_TAIL;
                r_tail_cnt <= CNT_W'(M);
            end else begin
                r_fsm <= ST_RUN;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end
`else
    // Output register and shift state; the last bit of a frame returns the state to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= {M{1'b0}};
            r_out_valid <= 1'b0;
            r_out_sym   <= {N_OUT{1'b0}};
            r_out_last  <= 1'b0;
        end else if (w_take) begin
            r_out_sym   <= encode_sym(w_reg_vec);
            r_out_valid <= 1'b1;
            r_out_last  <= in_last;
            if (in_last) begin
                r_state <= {M{1'b0}};
            end else begin
                r_state <= w_reg_vec[M-1:0];
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign out_sym   = r_out_sym;
    assign out_last  = r_out_last;
    assign enc_state = r_state;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: scoreboard against a reference encoder model,
// default code (K=5, N_OUT=2) plus an N_OUT=3 instance driven with a random frame.
module tb_conv_encoder;

    localparam int          K   = 5;
    localparam int          M   = K - 1;
    localparam logic [14:0] GM1 = 15'h03B3;
    localparam logic [14:0] GM2 = {5'o37, 5'o33, 5'o25};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, out_last;
    logic [1:0] out_sym;
    logic [M-1:0] enc_state;

    logic       iv2 = 1'b0, ib2 = 1'b0, il2 = 1'b0, ordy2 = 1'b0;
    logic       ir2, ov2, ol2;
    logic [2:0] os2;
    logic [M-1:0] es2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [3:0] rdy_pat = 4'b1111;

    logic [4:0] q1[$];
    logic [4:0] q2[$];
    logic [4:0] seen[$];
    logic [M-1:0] m_state1 = '0;
    logic [M-1:0] m_state2 = '0;

    always #5 clk = ~clk;

    conv_encoder #(.K(5), .N_OUT(2), .G_OCT(10'h3B3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_sym(out_sym), .out_last(out_last), .enc_state(enc_state)
    );

    conv_encoder #(.K(5), .N_OUT(3), .G_OCT(GM2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .in_bit(ib2), .in_last(il2), .out_valid(ov2), .out_ready(ordy2),
        .out_sym(os2), .out_last(ol2), .enc_state(es2)
    );

    function automatic logic [3:0] sym_of(input int n, input logic [14:0] g, input logic [4:0] rv);
        logic [3:0] s;
        s = 4'b0000;
        for (int i = 0; i < n; i++) s[n-1-i] = ^(rv & g[i*5 +: 5]);
        return s;
    endfunction

    task automatic push_exp(input int w, input logic [4:0] e);
        if (w == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    // Reference encoder: push every symbol the accepted bit implies (including any tail).
    task automatic model_push(input int w, input logic b, input logic l);
        logic [M-1:0] st;
        logic [4:0]   rv;
        int           n;
        logic [14:0]  g;
        st = (w == 1) ? m_state1 : m_state2;
        n  = (w == 1) ? 2 : 3;
        g  = (w == 1) ? GM1 : GM2;
        rv = {st, b};
`ifdef CONV_ENC_TAIL_EN
        push_exp(w, {1'b0, sym_of(n, g, rv)});
        st = rv[M-1:0];
        if (l) begin
            for (int j = 0; j < M; j++) begin
                rv = {st, 1'b0};
                push_exp(w, {(j == M - 1), sym_of(n, g, rv)});
                st = rv[M-1:0];
            end
        end
`else
        push_exp(w, {l, sym_of(n, g, rv)});
        st = l ? '0 : rv[M-1:0];
`endif
        if (w == 1) m_state1 = st;
        else m_state2 = st;
    endtask

    logic       hold_v1 = 1'b0;
    logic [2:0] hold_e1;
    logic [4:0] e1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_v1 && out_valid) begin
                checks++;
                if ({out_last, out_sym} !== hold_e1) begin
                    failures++;
                    $display("FAIL stall_hold: got %b required %b", {out_last, out_sym}, hold_e1);
                end
            end
            hold_v1 = out_valid && !out_ready;
            hold_e1 = {out_last, out_sym};
            if (out_valid && out_ready) begin
                checks++;
                seen.push_back({out_last, 2'b00, out_sym});
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL sb1_unexpected: got sym=%b last=%b with empty queue", out_sym, out_last);
                end else begin
                    e1 = q1.pop_front();
                    if ({out_last, 2'b00, out_sym} !== e1) begin
                        failures++;
                        $display("FAIL sb1_symbol: got last=%b sym=%b required last=%b sym=%b",
                                 out_last, out_sym, e1[4], e1[1:0]);
                    end
                end
            end
        end else begin
            hold_v1 = 1'b0;
        end
    end

    logic [4:0] e2;
    always @(negedge clk) begin
        if (rst_n && ov2 && ordy2) begin
            checks++;
            if (q2.size() == 0) begin
                failures++;
                $display("FAIL sb3_unexpected: got sym=%b last=%b with empty queue", os2, ol2);
            end else begin
                e2 = q2.pop_front();
                if ({ol2, 1'b0, os2} !== e2) begin
                    failures++;
                    $display("FAIL sb3_symbol: got last=%b sym=%b required last=%b sym=%b",
                             ol2, os2, e2[4], e2[2:0]);
                end
            end
        end
    end

    task automatic step1(input logic iv, input logic ib, input logic il, output logic took);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_bit    = ib;
        in_last   = il;
        out_ready = rdy_pat[cyc % 4];
        cyc++;
        #1;
        took = iv && in_ready;
        if (took) model_push(1, ib, il);
    endtask

    task automatic send1(input logic b, input logic l);
        logic took;
        took = 1'b0;
        for (int t = 0; t < 50 && !took; t++) step1(1'b1, b, l, took);
        if (!took) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: bit not accepted within 50 cycles");
        end
    endtask

    task automatic drain1();
        logic took;
        bit   done;
        done = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            step1(1'b0, 1'b0, 1'b0, took);
            if (q1.size() == 0 && !out_valid) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout: %0d symbols outstanding", q1.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        if (out_sym !== 2'b00) begin failures++; $display("FAIL reset_out_sym: got %b required 00", out_sym); end
        if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b required 0", out_last); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        if (enc_state !== 4'b0000) begin failures++; $display("FAIL reset_enc_state: got %b required 0000", enc_state); end
    endtask

    task automatic test_impulse();
        logic [2:0] exp_tab [5];
        int         nready0;
        int         exp_nready0;
        logic       took;
        exp_tab = '{3'b011, 3'b010, 3'b001, 3'b001, 3'b111};
        rdy_pat = 4'b1111;
        seen.delete();
`ifdef CONV_ENC_TAIL_EN
        send1(1'b1, 1'b1);
        exp_nready0 = 4;
`else
        send1(1'b1, 1'b0);
        send1(1'b0, 1'b0);
        send1(1'b0, 1'b0);
        send1(1'b0, 1'b0);
        send1(1'b0, 1'b1);
        exp_nready0 = 0;
`endif
        nready0 = 0;
        for (int t = 0; t < 8; t++) begin
            step1(1'b0, 1'b0, 1'b0, took);
            if (!in_ready) nready0++;
        end
        drain1();
        checks++;
        if (nready0 != exp_nready0) begin
            failures++;
            $display("FAIL impulse_in_ready_low: got %0d cycles required %0d", nready0, exp_nready0);
        end
        checks++;
        if (seen.size() != 5) begin
            failures++;
            $display("FAIL impulse_count: got %0d symbols required 5", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if ({seen[i][4], seen[i][1:0]} !== exp_tab[i]) begin
                    failures++;
                    $display("FAIL impulse_sym%0d: got last=%b sym=%b required last=%b sym=%b",
                             i, seen[i][4], seen[i][1:0], exp_tab[i][2], exp_tab[i][1:0]);
                end
            end
        end
        checks++;
        if (enc_state !== 4'b0000) begin
            failures++;
            $display("FAIL impulse_enc_state: got %b required 0000", enc_state);
        end
    endtask

    task automatic test_backpressure();
        rdy_pat = 4'b1001;
        cyc = 0;
        seen.delete();
        send1(1'b1, 1'b0);
        send1(1'b1, 1'b0);
        send1(1'b0, 1'b0);
        send1(1'b1, 1'b1);
        drain1();
        checks++;
`ifdef CONV_ENC_TAIL_EN
        if (seen.size() != 4 + M) begin
            failures++;
            $display("FAIL bp_count: got %0d symbols required %0d", seen.size(), 4 + M);
        end
`else
        if (seen.size() != 4) begin
            failures++;
            $display("FAIL bp_count: got %0d symbols required 4", seen.size());
        end
`endif
        rdy_pat = 4'b1111;
    endtask

    task automatic test_back_to_back();
        int idx;
        rdy_pat = 4'b1111;
        seen.delete();
        send1(1'b0, 1'b0);
        send1(1'b0, 1'b0);
        send1(1'b0, 1'b0);
        send1(1'b1, 1'b1);
        send1(1'b1, 1'b0);
        send1(1'b0, 1'b1);
        drain1();
`ifdef CONV_ENC_TAIL_EN
        idx = 4 + M;
`else
        idx = 4;
`endif
        checks++;
        if (seen.size() <= idx) begin
            failures++;
            $display("FAIL b2b_count: got %0d symbols required more than %0d", seen.size(), idx);
        end else if (seen[idx][1:0] !== 2'b11) begin
            failures++;
            $display("FAIL b2b_first_sym: got %b required 11", seen[idx][1:0]);
        end
    endtask

    task automatic test_reset_mid();
        rdy_pat = 4'b1111;
        send1(1'b1, 1'b0);
        send1(1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
        if (enc_state !== 4'b0000) begin failures++; $display("FAIL rstmid_enc_state: got %b required 0000", enc_state); end
        q1.delete();
        m_state1 = '0;
        seen.delete();
        send1(1'b1, 1'b1);
        drain1();
        checks++;
        if (seen.size() == 0) begin
            failures++;
            $display("FAIL rstmid_count: got 0 symbols required at least 1");
        end else if (seen[0][1:0] !== 2'b11) begin
            failures++;
            $display("FAIL rstmid_first_sym: got %b required 11", seen[0][1:0]);
        end
    endtask

    task automatic test_n3_random();
        int  sent;
        int  t;
        bit  done;
        logic b;
        sent = 0;
        t = 0;
        b = 1'($urandom_range(0, 1));
        while (sent < 200 && t < 3000) begin
            @(posedge clk);
            #1;
            iv2   = ($urandom_range(0, 3) != 0);
            ib2   = b;
            il2   = (sent == 199);
            ordy2 = ($urandom_range(0, 3) != 0);
            #1;
            if (iv2 && ir2) begin
                model_push(2, ib2, il2);
                sent++;
                b = 1'($urandom_range(0, 1));
            end
            t++;
        end
        checks++;
        if (sent != 200) begin
            failures++;
            $display("FAIL n3_send_timeout: sent %0d bits required 200", sent);
        end
        done = 0;
        for (int d = 0; d < 200 && !done; d++) begin
            @(posedge clk);
            #1;
            iv2 = 1'b0;
            ordy2 = 1'b1;
            #1;
            if (q2.size() == 0 && !ov2) done = 1;
        end
        checks += 2;
        if (!done) begin
            failures++;
            $display("FAIL n3_drain: %0d symbols outstanding", q2.size());
        end
        if (es2 !== 4'b0000) begin
            failures++;
            $display("FAIL n3_enc_state: got %b required 0000", es2);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_n3_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
